div_iter: RTL

Iterative 32-bit radix-2 restoring divider for DIV/DIVU in the EXE stage. It produces the remainder/quotient pair that the pipeline carries to the MEM-stage HI/LO register as hi/lo write data. The EXE stage stalls on it while a division is in flight. A division is aborted when the instruction is flushed by an exception.

---
 rtl/div_iter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/div_iter.sv
//==============================================================================
// Module      : div_iter
// Description : Iterative 32-bit radix-2 restoring divider (DIV/DIVU) producing
//               {remainder, quotient} for the HI/LO write path.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module div_iter (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        signed_div,
  input  logic        annul,
  input  logic [31:0] opdata1,
  input  logic [31:0] opdata2,
  output logic [63:0] result,
  output logic        ready,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quot_q, quot_d;
  logic [31:0] divisor_q, divisor_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        negq_q, negq_d;
  logic        negr_q, negr_d;
  logic [63:0] result_q, result_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;

  logic [32:0] w_shifted;
  logic [32:0] w_trial;
  logic [31:0] w_step_quot;
  logic [31:0] w_step_rem;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;

  // The quotient register doubles as the dividend shifter: its MSB feeds the
  // partial remainder while the new quotient bit enters at the LSB.
  always_comb begin
    w_shifted   = {rem_q, quot_q[31]};
    w_trial     = w_shifted - {1'b0, divisor_q};
    w_step_quot = {quot_q[30:0], ~w_trial[32]};
    w_step_rem  = w_trial[32] ? w_shifted[31:0] : w_trial[31:0];
    w_abs_a     = (signed_div && opdata1[31]) ? (~opdata1 + 32'd1) : opdata1;
    w_abs_b     = (signed_div && opdata2[31]) ? (~opdata2 + 32'd1) : opdata2;
  end

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    quot_d    = quot_q;
    divisor_d = divisor_q;
    cnt_d     = cnt_q;
    negq_d    = negq_q;
    negr_d    = negr_q;
    result_d  = result_q;

    case (state_q)
      S_IDLE: begin
        if (start && !annul) begin
          if (opdata2 == 32'd0) begin
            result_d = {opdata1, 32'hFFFF_FFFF};
            state_d  = S_DONE;
          end else begin
            quot_d    = w_abs_a;
            divisor_d = w_abs_b;
            negq_d    = signed_div & (opdata1[31] ^ opdata2[31]);
            negr_d    = signed_div & opdata1[31];
            rem_d     = 32'd0;
            cnt_d     = 5'd0;
            state_d   = S_ON;
          end
        end
      end
      S_ON: begin
        if (annul) begin
          state_d = S_IDLE;
        end else begin
          rem_d  = w_step_rem;
          quot_d = w_step_quot;
          cnt_d  = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            result_d[63:32] = negr_q ? (~w_step_rem + 32'd1) : w_step_rem;
            result_d[31:0]  = negq_q ? (~w_step_quot + 32'd1) : w_step_quot;
            state_d         = S_DONE;
          end
        end
      end
      S_DONE: begin
        // Hold the result until the pipeline releases start; no restart.
        if (!start || annul) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d  = (state_d == S_ON);
    ready_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rem_q     <= 32'd0;
      quot_q    <= 32'd0;
      divisor_q <= 32'd0;
      cnt_q     <= 5'd0;
      negq_q    <= 1'b0;
      negr_q    <= 1'b0;
      result_q  <= 64'd0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      quot_q    <= quot_d;
      divisor_q <= divisor_d;
      cnt_q     <= cnt_d;
      negq_q    <= negq_d;
      negr_q    <= negr_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
    end
  end

  assign result = result_q;
  assign ready  = ready_q;
  assign busy   = busy_q;

endmodule

`default_nettype wire
